// File: rtl/sb_defs_pkg.sv
// Shared definitions for the store buffer: sizing constants, the full byte-enable
// pattern, and the layout of one buffered store.
package sb_defs;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  localparam int SB_AW    = 32;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Only the word address is kept; the byte offset never takes part in matching.
  typedef struct packed {
    logic              valid;
    logic [SB_AW-3:0]  addr;
    logic [31:0]       data;
    logic [3:0]        be;
    logic [31:0]       pc;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Parallel word-address comparator with a youngest-first priority select.
// The youngest entry is the one just behind tail, so the search walks backwards from there.
module sb_match #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 30,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][WORD_W-1:0] word_addr,
  input  logic [DEPTH-1:0]             full_be,
  input  logic [WORD_W-1:0]            ld_word,
  input  logic [PTR_W-1:0]             tail,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx,
  output logic                         be_full
);

  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] slot;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (word_addr[i] == ld_word);
    end
  end

  // First match found while walking from tail-1 towards the head wins.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    be_full = 1'b0;
    slot    = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      slot = tail - PTR_W'(k);
      if (!hit && match[slot]) begin
        hit     = 1'b1;
        idx     = slot;
        be_full = full_be[slot];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between execute and data memory, with load forwarding
// for fully covering stores and a stall for partially covering ones.
module store_buffer
  import sb_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_be,
  input  logic [31:0]   st_pc,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_fwd,
  output logic [31:0]   ld_data,
  output logic          ld_stall,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_pc,
  input  logic          dm_ready,
  output logic          empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = AW - 2;

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic enq;
  logic deq;

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][WORD_W-1:0] ent_word;
  logic [DEPTH-1:0]             ent_full;
  logic                         m_hit;
  logic [PTR_W-1:0]             m_idx;
  logic                         m_full;

  logic unused_bits;
  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready = (count < (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign dm_we    = !empty;
  assign enq      = st_valid && st_ready && (st_be != 4'b0000);
  assign deq      = dm_we && dm_ready;

  // Pointers and occupancy; simultaneous enqueue/dequeue leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  // Enqueue and dequeue never target the same slot: enq needs a free slot, deq a full one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (deq) entries[head].valid <= 1'b0;
      if (enq) begin
        entries[tail].valid <= 1'b1;
        entries[tail].addr  <= st_addr[AW-1:2];
        entries[tail].data  <= st_data;
        entries[tail].be    <= st_be;
        entries[tail].pc    <= st_pc;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_word[i]  = entries[i].addr;
      ent_full[i]  = (entries[i].be == BE_FULL);
    end
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .valid     (ent_valid),
    .word_addr (ent_word),
    .full_be   (ent_full),
    .ld_word   (ld_addr[AW-1:2]),
    .tail      (tail),
    .hit       (m_hit),
    .idx       (m_idx),
    .be_full   (m_full)
  );

  assign ld_fwd   = ld_valid && m_hit && m_full;
  assign ld_stall = ld_valid && m_hit && !m_full;
  assign ld_data  = ld_fwd ? entries[m_idx].data : 32'h0;

  // Memory-side outputs are held at zero whenever nothing is presented.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    dm_pc    = '0;
    if (dm_we) begin
      dm_addr  = {entries[head].addr, 2'b00};
      dm_wdata = entries[head].data;
      dm_be    = entries[head].be;
      dm_pc    = entries[head].pc;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based model of the buffered stores.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_fwd;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } store_t;

  store_t mq[$];

  store_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_fwd   (ld_fwd),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_pc    (dm_pc),
    .dm_ready (dm_ready),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Youngest buffered store to the load's word decides the lookup result.
  function automatic int find_youngest(input logic [31:0] a);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].word == a[31:2]) return i;
    end
    return -1;
  endfunction

  function automatic logic exp_fwd();
    int i;
    i = find_youngest(ld_addr);
    return ld_valid && (i >= 0) && (mq[i].be == 4'hF);
  endfunction

  function automatic logic exp_stall();
    int i;
    i = find_youngest(ld_addr);
    return ld_valid && (i >= 0) && (mq[i].be != 4'hF);
  endfunction

  function automatic logic [31:0] exp_ldata();
    int i;
    i = find_youngest(ld_addr);
    if (ld_valid && (i >= 0) && (mq[i].be == 4'hF)) return mq[i].data;
    return 32'h0;
  endfunction

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = pc;
  endtask

  // Apply one clock edge and update the model with what the edge should do.
  task automatic advance();
    bit enq, deq;
    store_t s;
    enq = st_valid && (mq.size() < DEPTH) && (st_be != 4'b0000);
    deq = (mq.size() > 0) && dm_ready;
    s.word = st_addr[31:2];
    s.data = st_data;
    s.be   = st_be;
    s.pc   = st_pc;
    @(posedge clk);
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_addr  = 32'h40;
    dm_ready = 1'b0;
    set_store(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h100);
    repeat (3) @(negedge clk);
    n_checks++;
    if (st_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_st_ready got=%b exp=1", st_ready); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    n_checks++;
    if (dm_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dm_we got=%b exp=0", dm_we); end
    n_checks++;
    if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_dm_bus got=%h/%h exp=0/0", dm_addr, dm_wdata);
    end
    st_valid = 1'b0;
    reset    = 1'b0;
    mq.delete();
    advance();
    ld_valid = 1'b1;
    #1;
    n_checks++;
    if (empty !== 1'b1 || dm_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_reset_empty got=%b/%b exp=1/0", empty, dm_we);
    end
    n_checks++;
    if (ld_fwd !== 1'b0 || ld_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_reset_lookup got=%b/%b exp=0/0", ld_fwd, ld_stall);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 32'h200 + 32'(i * 4));
      advance();
    end
    set_store(1'b1, 32'h10, 32'h55, 4'hF, 32'h210);
    #1;
    n_checks++;
    if (st_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_st_ready got=%b exp=0", st_ready); end
    advance();
    st_valid = 1'b0;
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (dm_we !== 1'b1 || dm_addr !== 32'(i * 4) || dm_wdata !== 32'hA0 + 32'(i)) begin
        n_fail++;
        $display("[TB] FAIL drain_order[%0d] got=%b/%h/%h exp=1/%h/%h", i, dm_we, dm_addr, dm_wdata,
                 32'(i * 4), 32'hA0 + 32'(i));
      end
      advance();
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drained_empty got=%b exp=1", empty); end
  endtask

  task automatic test_forward();
    dm_ready = 1'b0;
    set_store(1'b1, 32'h10, 32'h11111111, 4'hF, 32'h300);
    advance();
    set_store(1'b1, 32'h10, 32'h22222222, 4'hF, 32'h304);
    advance();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h12;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'h22222222 || ld_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fwd_youngest got=%b/%h/%b exp=1/22222222/0", ld_fwd, ld_data, ld_stall);
    end
    ld_valid = 1'b0;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b0 || ld_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL fwd_no_valid got=%b/%h exp=0/0", ld_fwd, ld_data);
    end
    dm_ready = 1'b1;
    for (int i = 0; i < 8 && mq.size() > 0; i++) advance();
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_drain got=%b exp=1", empty); end
  endtask

  task automatic test_partial_stall();
    dm_ready = 1'b0;
    set_store(1'b1, 32'h20, 32'h0000BEEF, 4'b0011, 32'h400);
    advance();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ld_stall !== 1'b1 || ld_fwd !== 1'b0) begin
        n_fail++; $display("[TB] FAIL stall_hold[%0d] got=%b/%b exp=1/0", i, ld_stall, ld_fwd);
      end
      advance();
    end
    dm_ready = 1'b1;
    #1;
    n_checks++;
    if (ld_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_on_dequeue got=%b exp=1", ld_stall); end
    advance();
    #1;
    n_checks++;
    if (ld_stall !== 1'b0 || ld_fwd !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_release got=%b/%b exp=0/0", ld_stall, ld_fwd);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_full_wrap();
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h100 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF, 32'h500 + 32'(i));
      advance();
    end
    dm_ready = 1'b1;
    set_store(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 32'h600);
    #1;
    n_checks++;
    if (st_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_deq_refuse got=%b exp=0", st_ready); end
    advance();
    dm_ready = 1'b0;
    #1;
    n_checks++;
    if (st_ready !== 1'b1 || mq.size() != 3) begin
      n_fail++; $display("[TB] FAIL full_deq_count got=%b exp=1 (model size %0d)", st_ready, mq.size());
    end
    advance();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    #1;
    n_checks++;
    if (ld_fwd !== 1'b1 || ld_data !== 32'hCAFEF00D) begin
      n_fail++; $display("[TB] FAIL wrap_fwd got=%b/%h exp=1/cafef00d", ld_fwd, ld_data);
    end
    ld_valid = 1'b0;
    dm_ready = 1'b1;
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin
      #1;
      n_checks++;
      if (dm_addr !== {mq[0].word, 2'b00} || dm_pc !== mq[0].pc) begin
        n_fail++; $display("[TB] FAIL wrap_drain[%0d] got=%h/%h exp=%h/%h", i, dm_addr, dm_pc,
                           {mq[0].word, 2'b00}, mq[0].pc);
      end
      advance();
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_async_reset();
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h300 + 32'(i * 4), 32'hE0 + 32'(i), 4'hF, 32'h700);
      advance();
    end
    st_valid = 1'b0;
    dm_ready = 1'b1;
    advance();
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    n_checks++;
    if (dm_we !== 1'b0 || empty !== 1'b1 || dm_addr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL async_reset got=%b/%b/%h exp=0/1/0", dm_we, empty, dm_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (dm_we !== 1'b0) begin n_fail++; $display("[TB] FAIL async_no_present[%0d] got=%b exp=0", i, dm_we); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] addr_pool [4];
    addr_pool = '{32'h00, 32'h04, 32'h08, 32'h40};
    for (int c = 0; c < 400; c++) begin
      set_store($urandom_range(0, 3) != 0, addr_pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
                $urandom, ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'hF, $urandom);
      dm_ready = $urandom_range(0, 2) == 0;
      ld_valid = $urandom_range(0, 1) == 1;
      ld_addr  = addr_pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (ld_fwd !== exp_fwd() || ld_stall !== exp_stall() || ld_data !== exp_ldata()) begin
        n_fail++; $display("[TB] FAIL rand_lookup[%0d] got=%b/%b/%h exp=%b/%b/%h", c, ld_fwd, ld_stall,
                           ld_data, exp_fwd(), exp_stall(), exp_ldata());
      end
      n_checks++;
      if (st_ready !== (mq.size() < DEPTH) || empty !== (mq.size() == 0) || dm_we !== (mq.size() != 0)) begin
        n_fail++; $display("[TB] FAIL rand_status[%0d] got=%b/%b/%b model_size=%0d", c, st_ready, empty,
                           dm_we, mq.size());
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (dm_addr !== {mq[0].word, 2'b00} || dm_wdata !== mq[0].data || dm_be !== mq[0].be ||
            dm_pc !== mq[0].pc) begin
          n_fail++; $display("[TB] FAIL rand_head[%0d] got=%h/%h/%h/%h exp=%h/%h/%h/%h", c, dm_addr,
                             dm_wdata, dm_be, dm_pc, {mq[0].word, 2'b00}, mq[0].data, mq[0].be, mq[0].pc);
        end
      end
      advance();
    end
    st_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_forward();
    test_partial_stall();
    test_full_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
